// File: rtl/sensor_bus_if.sv
// Handshake and data bundle between the sensor arbiter (master) and the
// requesting controllers plus the shared DHT11 driver (slave).
interface sensor_bus_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         start_sensor;
  logic         sensor_done;
  logic [0:39]  sensor_data;
  logic         error;
  logic [0:39]  data_out;
  logic [N-1:0] data_valid;
  logic         data_error;

  modport master (
    input  req, sensor_done, sensor_data, error,
    output grant, start_sensor, data_out, data_valid, data_error
  );

  modport slave (
    output req, sensor_done, sensor_data, error,
    input  grant, start_sensor, data_out, data_valid, data_error
  );
endinterface

// File: rtl/sensor_bus_arbiter.sv
// Round-robin arbiter sharing one DHT11 driver among N controllers; each read
// runs start -> wait done/timeout -> deliver -> guard gap.
module sensor_bus_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 220,
  parameter int GAP     = 16
) (
  input  logic      clk_9600hz,
  input  logic      reset,
  sensor_bus_if.master bus
);

  localparam int               PTR_W        = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W:0]   N_W          = (PTR_W + 1)'(N);
  localparam logic [N-1:0]     ONE_LSB      = {{(N - 1){1'b0}}, 1'b1};
  localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0]      GAP_LAST     = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DELIVER = 2'd2,
    ST_GUARD   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [PTR_W-1:0]   owner_r, owner_s;
  logic [PTR_W-1:0]   pick_s;
  logic               pick_valid_s;
  logic [15:0]        timer_r, timer_s;
  logic [N-1:0]       grant_r, grant_s;
  logic [N-1:0]       data_valid_r, data_valid_s;
  logic               start_r, start_s;
  logic               data_error_r, data_error_s;
  logic [0:39]        data_out_r, data_out_s;

  // Index arithmetic modulo N; sum never exceeds 2N-2, so one subtraction suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [PTR_W:0]   off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= N_W) begin
      sum = sum - N_W;
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  // Round-robin pick: scan from highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_s       = rr_ptr_r;
    pick_valid_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[wrap_add(rr_ptr_r, (PTR_W + 1)'(i))]) begin
        pick_s       = wrap_add(rr_ptr_r, (PTR_W + 1)'(i));
        pick_valid_s = 1'b1;
      end else begin
        pick_s       = pick_s;
      end
    end
  end

  // Next-state and next-output logic for the read sequencer.
  always_comb begin
    state_s      = state_r;
    rr_ptr_s     = rr_ptr_r;
    owner_s      = owner_r;
    timer_s      = timer_r;
    grant_s      = grant_r;
    start_s      = 1'b0;
    data_valid_s = {N{1'b0}};
    data_out_s   = data_out_r;
    data_error_s = data_error_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          owner_s = pick_s;
          grant_s = ONE_LSB << pick_s;
          start_s = 1'b1;
          timer_s = 16'd0;
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        timer_s = timer_r + 16'd1;
        // A completion on the timeout edge still counts as a real result.
        if (bus.sensor_done) begin
          data_out_s   = bus.sensor_data;
          data_error_s = bus.error;
          data_valid_s = ONE_LSB << owner_r;
          state_s      = ST_DELIVER;
        end else if (timer_r == TIMEOUT_LAST) begin
          data_out_s   = 40'h00_0000_0000;
          data_error_s = 1'b1;
          data_valid_s = ONE_LSB << owner_r;
          state_s      = ST_DELIVER;
        end else begin
          state_s      = ST_BUSY;
        end
      end
      ST_DELIVER: begin
        grant_s  = {N{1'b0}};
        rr_ptr_s = wrap_add(owner_r, (PTR_W + 1)'(1));
        timer_s  = 16'd0;
        if (GAP == 0) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (timer_r == GAP_LAST) begin
          timer_s = 16'd0;
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r + 16'd1;
          state_s = ST_GUARD;
        end
      end
      default: begin
        grant_s = {N{1'b0}};
        timer_s = 16'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_9600hz) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= {PTR_W{1'b0}};
      owner_r      <= {PTR_W{1'b0}};
      timer_r      <= 16'd0;
      grant_r      <= {N{1'b0}};
      data_valid_r <= {N{1'b0}};
      start_r      <= 1'b0;
      data_error_r <= 1'b0;
      data_out_r   <= 40'h00_0000_0000;
    end else begin
      state_r      <= state_s;
      rr_ptr_r     <= rr_ptr_s;
      owner_r      <= owner_s;
      timer_r      <= timer_s;
      grant_r      <= grant_s;
      data_valid_r <= data_valid_s;
      start_r      <= start_s;
      data_error_r <= data_error_s;
      data_out_r   <= data_out_s;
    end
  end

  assign bus.grant        = grant_r;
  assign bus.start_sensor = start_r;
  assign bus.data_out     = data_out_r;
  assign bus.data_valid   = data_valid_r;
  assign bus.data_error   = data_error_r;

endmodule
